// File: rtl/vga_timing_gen_if.sv
// Raster-timing bus between the VGA timing generator and its consumers (renderer, sync pins).
// The generator drives everything except enable.
interface vga_timing_gen_if;
  logic       enable;
  logic       pixel_ce;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       active;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;

  modport master (
    input  enable,
    output pixel_ce, pix_x, pix_y, active, hsync, vsync, line_start, frame_start
  );

  modport slave (
    output enable,
    input  pixel_ce, pix_x, pix_y, active, hsync, vsync, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: divides the system clock into a pixel strobe and produces raster position,
// active video, hsync/vsync and line/frame start pulses, all registered on the strobe edge.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 5,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input logic              clock,
  input logic              reset,
  vga_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  // Last coordinate of each phase; every phase is assumed to span at least one pixel/line.
  localparam logic [9:0] HActLast = 10'(H_ACTIVE - 1);
  localparam logic [9:0] HFpLast  = 10'(H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] HSyLast  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VActLast = 10'(V_ACTIVE - 1);
  localparam logic [9:0] VFpLast  = 10'(V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] VSyLast  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);

  localparam logic SyncOn  = SYNC_POL;
  localparam logic SyncOff = ~SYNC_POL;

  typedef enum logic [1:0] {HAct, HFp, HSy, HBp} hPhaseT;
  typedef enum logic [1:0] {VAct, VFp, VSy, VBp} vPhaseT;

  logic [DivW-1:0] divQ, divD;
  logic [9:0]      posXQ, posXD, posYQ, posYD;
  hPhaseT          hPhaseQ, hPhaseD;
  vPhaseT          vPhaseQ, vPhaseD;
  logic            ceQ, ceD;
  logic [9:0]      pixXQ, pixXD, pixYQ, pixYD;
  logic            activeQ, activeD;
  logic            hsyncQ, hsyncD, vsyncQ, vsyncD;
  logic            lineStartQ, lineStartD, frameStartQ, frameStartD;
  logic            divWrap, xWrap;

  always_comb begin
    divWrap     = (divQ == DivLast);
    xWrap       = (posXQ == HLast);
    divD        = divWrap ? '0 : divQ + 1'b1;
    ceD         = divWrap;
    posXD       = posXQ;
    posYD       = posYQ;
    hPhaseD     = hPhaseQ;
    vPhaseD     = vPhaseQ;
    pixXD       = pixXQ;
    pixYD       = pixYQ;
    activeD     = activeQ;
    hsyncD      = hsyncQ;
    vsyncD      = vsyncQ;
    lineStartD  = 1'b0;
    frameStartD = 1'b0;

    if (divWrap) begin
      posXD = xWrap ? 10'd0 : posXQ + 10'd1;
      if (xWrap) begin
        posYD = (posYQ == VLast) ? 10'd0 : posYQ + 10'd1;
      end

      unique case (hPhaseQ)
        HAct: if (posXQ == HActLast) hPhaseD = HFp;
        HFp:  if (posXQ == HFpLast)  hPhaseD = HSy;
        HSy:  if (posXQ == HSyLast)  hPhaseD = HBp;
        HBp:  if (posXQ == HLast)    hPhaseD = HAct;
      endcase

      // Vertical phase only moves on the line boundary.
      if (xWrap) begin
        unique case (vPhaseQ)
          VAct: if (posYQ == VActLast) vPhaseD = VFp;
          VFp:  if (posYQ == VFpLast)  vPhaseD = VSy;
          VSy:  if (posYQ == VSyLast)  vPhaseD = VBp;
          VBp:  if (posYQ == VLast)    vPhaseD = VAct;
        endcase
      end

      // Outputs describe the position just entered, so they leave on the same edge.
      pixXD       = posXD;
      pixYD       = posYD;
      activeD     = (hPhaseD == HAct) && (vPhaseD == VAct);
      hsyncD      = (hPhaseD == HSy) ? SyncOn : SyncOff;
      vsyncD      = (vPhaseD == VSy) ? SyncOn : SyncOff;
      lineStartD  = (posXD == 10'd0);
      frameStartD = (posXD == 10'd0) && (posYD == 10'd0);
    end

    // Idle parks everything at the reset state so re-enable starts a fresh frame.
    if (!bus.enable) begin
      divD        = '0;
      ceD         = 1'b0;
      posXD       = HLast;
      posYD       = VLast;
      hPhaseD     = HBp;
      vPhaseD     = VBp;
      pixXD       = 10'd0;
      pixYD       = 10'd0;
      activeD     = 1'b0;
      hsyncD      = SyncOff;
      vsyncD      = SyncOff;
      lineStartD  = 1'b0;
      frameStartD = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      divQ        <= '0;
      ceQ         <= 1'b0;
      posXQ       <= HLast;
      posYQ       <= VLast;
      hPhaseQ     <= HBp;
      vPhaseQ     <= VBp;
      pixXQ       <= 10'd0;
      pixYQ       <= 10'd0;
      activeQ     <= 1'b0;
      hsyncQ      <= SyncOff;
      vsyncQ      <= SyncOff;
      lineStartQ  <= 1'b0;
      frameStartQ <= 1'b0;
    end else begin
      divQ        <= divD;
      ceQ         <= ceD;
      posXQ       <= posXD;
      posYQ       <= posYD;
      hPhaseQ     <= hPhaseD;
      vPhaseQ     <= vPhaseD;
      pixXQ       <= pixXD;
      pixYQ       <= pixYD;
      activeQ     <= activeD;
      hsyncQ      <= hsyncD;
      vsyncQ      <= vsyncD;
      lineStartQ  <= lineStartD;
      frameStartQ <= frameStartD;
    end
  end

  assign bus.pixel_ce    = ceQ;
  assign bus.pix_x       = pixXQ;
  assign bus.pix_y       = pixYQ;
  assign bus.active      = activeQ;
  assign bus.hsync       = hsyncQ;
  assign bus.vsync       = vsyncQ;
  assign bus.line_start  = lineStartQ;
  assign bus.frame_start = frameStartQ;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, shrunk timing, CLK_DIV=1 with
// positive syncs) checked every clock against a raster model computed from the strobe count.
module tb_vga_timing_gen;

  typedef struct packed {
    int div, ha, hf, hs, hb, va, vf, vs, vb;
    bit pol;
  } timing_t;

  typedef struct packed {
    logic       ce;
    logic [9:0] x;
    logic [9:0] y;
    logic       act, hs, vs, ls, fs;
  } vgaOut_t;

  localparam timing_t CfgD = '{div: 5, ha: 640, hf: 16, hs: 96, hb: 48,
                               va: 480, vf: 10, vs: 2, vb: 33, pol: 1'b0};
  localparam timing_t CfgS = '{div: 5, ha: 16, hf: 3, hs: 5, hb: 4,
                               va: 6, vf: 2, vs: 2, vb: 3, pol: 1'b0};
  localparam timing_t CfgF = '{div: 1, ha: 640, hf: 16, hs: 96, hb: 48,
                               va: 480, vf: 10, vs: 2, vb: 33, pol: 1'b1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_timing_gen_if ifD ();
  vga_timing_gen_if ifS ();
  vga_timing_gen_if ifF ();

  vga_timing_gen dutD (.clock(clk), .reset(rst), .bus(ifD));

  vga_timing_gen #(
    .CLK_DIV(CfgS.div), .H_ACTIVE(CfgS.ha), .H_FRONT(CfgS.hf), .H_SYNC(CfgS.hs),
    .H_BACK(CfgS.hb), .V_ACTIVE(CfgS.va), .V_FRONT(CfgS.vf), .V_SYNC(CfgS.vs),
    .V_BACK(CfgS.vb), .SYNC_POL(CfgS.pol)
  ) dutS (.clock(clk), .reset(rst), .bus(ifS));

  vga_timing_gen #(
    .CLK_DIV(CfgF.div), .SYNC_POL(CfgF.pol)
  ) dutF (.clock(clk), .reset(rst), .bus(ifF));

  vgaOut_t gotD, gotS, gotF, expD, expS, expF;
  assign gotD = {ifD.pixel_ce, ifD.pix_x, ifD.pix_y, ifD.active, ifD.hsync, ifD.vsync,
                 ifD.line_start, ifD.frame_start};
  assign gotS = {ifS.pixel_ce, ifS.pix_x, ifS.pix_y, ifS.active, ifS.hsync, ifS.vsync,
                 ifS.line_start, ifS.frame_start};
  assign gotF = {ifF.pixel_ce, ifF.pix_x, ifF.pix_y, ifF.active, ifF.hsync, ifF.vsync,
                 ifF.line_start, ifF.frame_start};

  int nVec = 0;
  int nErr = 0;
  // Clock edges since each raster last started running (0 = reset/idle).
  int nD = 0, nS = 0, nF = 0;

  // Strobe k (k = n/div - 1) shows raster index k mod frame size, scanned row by row.
  function automatic vgaOut_t model(input timing_t t, input int n);
    vgaOut_t o;
    int hTot, vTot, idx, x, y;
    hTot = t.ha + t.hf + t.hs + t.hb;
    vTot = t.va + t.vf + t.vs + t.vb;
    o = '0;
    o.hs = ~t.pol;
    o.vs = ~t.pol;
    if (n < t.div) return o;
    idx = (n / t.div - 1) % (hTot * vTot);
    x = idx % hTot;
    y = idx / hTot;
    o.ce  = ((n % t.div) == 0);
    o.x   = 10'(x);
    o.y   = 10'(y);
    o.act = (x < t.ha) && (y < t.va);
    if (x >= t.ha + t.hf && x < t.ha + t.hf + t.hs) o.hs = t.pol;
    if (y >= t.va + t.vf && y < t.va + t.vf + t.vs) o.vs = t.pol;
    o.ls = o.ce && (x == 0);
    o.fs = o.ls && (y == 0);
    return o;
  endfunction

  function automatic string fmt(input vgaOut_t v);
    return $sformatf("ce=%b xy=(%0d,%0d) act=%b hs=%b vs=%b ls=%b fs=%b",
                     v.ce, v.x, v.y, v.act, v.hs, v.vs, v.ls, v.fs);
  endfunction

  task automatic tick();
    @(posedge clk);
    nD = (rst || !ifD.enable) ? 0 : nD + 1;
    nS = (rst || !ifS.enable) ? 0 : nS + 1;
    nF = (rst || !ifF.enable) ? 0 : nF + 1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifD.enable = 1'b1;
    ifS.enable = 1'b1;
    ifF.enable = 1'b1;
    repeat (3) tick();
    expD = model(CfgD, 0);
    expS = model(CfgS, 0);
    expF = model(CfgF, 0);
    nVec++;
    if (gotD !== expD) begin
      nErr++;
      $display("FAIL reset_d got %s, expected %s", fmt(gotD), fmt(expD));
    end
    nVec++;
    if (gotS !== expS) begin
      nErr++;
      $display("FAIL reset_s got %s, expected %s", fmt(gotS), fmt(expS));
    end
    nVec++;
    if (gotF !== expF) begin
      nErr++;
      $display("FAIL reset_f got %s, expected %s", fmt(gotF), fmt(expF));
    end
    ifS.enable = 1'b0;
    ifF.enable = 1'b0;
  endtask

  task automatic test_first_line();
    int firstCe = -1;
    int actCnt = 0;
    int syncCnt = 0;
    int lastLs = -1;
    #2 rst = 1'b0;
    for (int c = 1; c <= 8010; c++) begin
      tick();
      expD = model(CfgD, nD);
      nVec++;
      if (gotD !== expD) begin
        nErr++;
        $display("FAIL first_line n=%0d got %s, expected %s", nD, fmt(gotD), fmt(expD));
      end
      if (gotD.ce && firstCe < 0) firstCe = c;
      if (gotD.ce && gotD.y == 10'd0) begin
        if (gotD.act) actCnt++;
        if (!gotD.hs) syncCnt++;
      end
      if (gotD.ls) begin
        if (lastLs >= 0) begin
          nVec++;
          if (c - lastLs != 4000) begin
            nErr++;
            $display("FAIL line_period got %0d clocks, expected 4000", c - lastLs);
          end
        end
        lastLs = c;
      end
    end
    nVec++;
    if (firstCe != 5) begin
      nErr++;
      $display("FAIL first_strobe got clock %0d, expected 5", firstCe);
    end
    nVec++;
    if (actCnt != 640) begin
      nErr++;
      $display("FAIL active_count got %0d, expected 640", actCnt);
    end
    nVec++;
    if (syncCnt != 96) begin
      nErr++;
      $display("FAIL hsync_count got %0d, expected 96", syncCnt);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5000 && gotD.x !== 10'd700; i++) begin
      tick();
      expD = model(CfgD, nD);
      nVec++;
      if (gotD !== expD) begin
        nErr++;
        $display("FAIL to_hsync n=%0d got %s, expected %s", nD, fmt(gotD), fmt(expD));
      end
    end
    nVec++;
    if (gotD.x !== 10'd700 || gotD.hs !== 1'b0) begin
      nErr++;
      $display("FAIL reach_hsync got %s, expected x=700 hs=0", fmt(gotD));
    end
    #2 rst = 1'b1;
    #1;
    expD = model(CfgD, 0);
    nVec++;
    if (gotD !== expD) begin
      nErr++;
      $display("FAIL async_reset got %s, expected %s", fmt(gotD), fmt(expD));
    end
    tick();
    #2 rst = 1'b0;
  endtask

  task automatic test_enable_drop();
    int hold;
    for (int i = 0; i < 6000 && !(gotD.x === 10'd300 && gotD.y === 10'd1); i++) begin
      tick();
      expD = model(CfgD, nD);
      nVec++;
      if (gotD !== expD) begin
        nErr++;
        $display("FAIL to_drop n=%0d got %s, expected %s", nD, fmt(gotD), fmt(expD));
      end
    end
    nVec++;
    if (gotD.x !== 10'd300 || gotD.y !== 10'd1) begin
      nErr++;
      $display("FAIL reach_drop got %s, expected xy=(300,1)", fmt(gotD));
    end
    ifD.enable = 1'b0;
    hold = int'($urandom_range(1, 20));
    for (int i = 0; i < hold; i++) begin
      tick();
      expD = model(CfgD, 0);
      nVec++;
      if (gotD !== expD) begin
        nErr++;
        $display("FAIL idle i=%0d got %s, expected %s", i, fmt(gotD), fmt(expD));
      end
    end
    ifD.enable = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      expD = model(CfgD, nD);
      nVec++;
      if (gotD !== expD) begin
        nErr++;
        $display("FAIL reenable c=%0d got %s, expected %s", c, fmt(gotD), fmt(expD));
      end
    end
    nVec++;
    if (gotD.fs !== 1'b1 || gotD.ce !== 1'b1 || gotD.x !== 10'd0) begin
      nErr++;
      $display("FAIL reenable_frame got %s, expected ce=1 x=0 fs=1", fmt(gotD));
    end
    ifD.enable = 1'b0;
  endtask

  task automatic test_frame();
    int lastFs = -1;
    int frameIdx = 0;
    int vsCnt = 0;
    int wraps = 0;
    logic [9:0] prevX = '0, prevY = '0;
    ifS.enable = 1'b1;
    for (int c = 1; c <= 2 * 1820 + 30; c++) begin
      tick();
      expS = model(CfgS, nS);
      nVec++;
      if (gotS !== expS) begin
        nErr++;
        $display("FAIL frame n=%0d got %s, expected %s", nS, fmt(gotS), fmt(expS));
      end
      if (gotS.ce) begin
        if (frameIdx > 0 && prevX == 10'd27 && prevY == 10'd12) begin
          wraps++;
          nVec++;
          if (gotS.x !== 10'd0 || gotS.y !== 10'd0) begin
            nErr++;
            $display("FAIL frame_wrap got %s, expected xy=(0,0)", fmt(gotS));
          end
        end
        prevX = gotS.x;
        prevY = gotS.y;
      end
      if (gotS.fs) begin
        if (lastFs >= 0) begin
          nVec++;
          if (c - lastFs != 1820) begin
            nErr++;
            $display("FAIL frame_period got %0d clocks, expected 1820", c - lastFs);
          end
        end
        lastFs = c;
        frameIdx++;
      end
      if (gotS.ce && frameIdx == 1 && !gotS.vs) vsCnt++;
    end
    nVec++;
    if (vsCnt != 56 || wraps != 2) begin
      nErr++;
      $display("FAIL vsync_wrap got vs=%0d wraps=%0d, expected vs=56 wraps=2", vsCnt, wraps);
    end
    ifS.enable = 1'b0;
  endtask

  task automatic test_random_enable();
    ifS.enable = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (ifS.enable ? ($urandom_range(0, 599) == 0) : ($urandom_range(0, 3) == 0))
        ifS.enable = ~ifS.enable;
      tick();
      expS = model(CfgS, nS);
      nVec++;
      if (gotS !== expS) begin
        nErr++;
        $display("FAIL random_en n=%0d got %s, expected %s", nS, fmt(gotS), fmt(expS));
      end
    end
    ifS.enable = 1'b0;
  endtask

  task automatic test_fast();
    int syncCnt = 0;
    int lastLs = -1;
    ifF.enable = 1'b1;
    for (int c = 1; c <= 1700; c++) begin
      tick();
      expF = model(CfgF, nF);
      nVec++;
      if (gotF !== expF) begin
        nErr++;
        $display("FAIL fast n=%0d got %s, expected %s", nF, fmt(gotF), fmt(expF));
      end
      if (gotF.ce && gotF.y == 10'd0 && gotF.hs) syncCnt++;
      if (gotF.ls) begin
        if (lastLs >= 0) begin
          nVec++;
          if (c - lastLs != 800) begin
            nErr++;
            $display("FAIL fast_line_period got %0d clocks, expected 800", c - lastLs);
          end
        end
        lastLs = c;
      end
    end
    nVec++;
    if (syncCnt != 96) begin
      nErr++;
      $display("FAIL fast_hsync_count got %0d, expected 96", syncCnt);
    end
    ifF.enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ifD.enable = 1'b0;
    ifS.enable = 1'b0;
    ifF.enable = 1'b0;
    test_reset();
    test_first_line();
    test_async_reset();
    test_enable_drop();
    test_frame();
    test_random_enable();
    test_fast();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
